// File: rtl/pcs_lane_impair_if.sv
// Bundle of the data stream, configuration and status signals of pcs_lane_impair.
// The master side drives the stream and configuration. The slave side is the impairment block.
interface pcs_lane_impair_if #(
  parameter int LANES    = 4,
  parameter int W        = 40,
  parameter int MAX_SKEW = 8,
  parameter int SKW      = $clog2(MAX_SKEW),
  parameter int LW       = $clog2(LANES)
);
  localparam int BW = $clog2(W) + 1;

  logic                 in_valid;
  logic [LANES*W-1:0]   in_data;
  logic                 cfg_apply;
  logic [LANES*LW-1:0]  cfg_map;
  logic [LANES-1:0]     cfg_polar;
  logic [LANES*SKW-1:0] cfg_skew;
  logic [1:0]           cfg_err_mode;
  logic [LANES-1:0]     cfg_err_lane;
  logic [15:0]          cfg_err_period;
  logic [BW-1:0]        cfg_err_burst;
  logic                 out_valid;
  logic [LANES*W-1:0]   out_data;
  logic [31:0]          err_count;

  modport master (
    output in_valid, in_data, cfg_apply, cfg_map, cfg_polar, cfg_skew,
           cfg_err_mode, cfg_err_lane, cfg_err_period, cfg_err_burst,
    input  out_valid, out_data, err_count
  );

  modport slave (
    input  in_valid, in_data, cfg_apply, cfg_map, cfg_polar, cfg_skew,
           cfg_err_mode, cfg_err_lane, cfg_err_period, cfg_err_burst,
    output out_valid, out_data, err_count
  );
endinterface

// File: rtl/pcs_lane_impair.sv
// pcs_lane_impair: per-lane misconnection, polarity inversion, skew and bit-error
// injection between PCS transmit lanes and the receive side.
// Stage 1 maps and polarises each lane and writes a per-lane circular delay line.
// Stage 1 also captures the tap pointer and error mask of the word, so every word
// uses the configuration that was active when it entered.
// Stage 2 reads the tap, applies the error mask and accumulates the flip count.
// MAX_SKEW must be at least 2.
module pcs_lane_impair #(
  parameter int LANES    = 4,
  parameter int W        = 40,
  parameter int MAX_SKEW = 8,
  parameter int SKW      = $clog2(MAX_SKEW),
  parameter int LW       = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  pcs_lane_impair_if.slave bus
);
  localparam int BW = $clog2(W) + 1;
  localparam int PW = $clog2(W);
  localparam int CW = $clog2(LANES * W + 1);
  localparam int DW = LANES * W;

  // shadow configuration
  logic [LANES*LW-1:0]  mapCfg_q;
  logic [LANES-1:0]     polarCfg_q;
  logic [LANES*SKW-1:0] skewCfg_q;
  logic [1:0]           modeCfg_q;
  logic [LANES-1:0]     laneCfg_q;
  logic [15:0]          periodCfg_q;
  logic [BW-1:0]        burstCfg_q;

  // error engine state
  logic [15:0]   periodCnt_q, periodCnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [30:0]   lfsr_q, lfsr_d;

  // stage 1
  logic [SKW-1:0] wrPtr_q, wrPtr_d;
  logic [W-1:0]   dly_q [LANES][MAX_SKEW];
  logic           s1Valid_q;
  logic [SKW-1:0] rdPtr_q [LANES];
  logic [SKW-1:0] rdPtr_d [LANES];
  logic [W-1:0]   errMask_q [LANES];
  logic [W-1:0]   errMask_d [LANES];
  logic [CW-1:0]  flipCnt_q, flipCnt_d;
  logic [W-1:0]   laneWord [LANES];

  // error engine decode
  logic          periodic;
  logic          evt;
  logic          lfsrHit;
  logic [PW-1:0] randPos;
  logic [W-1:0]  flipBase;

  // stage 2
  logic          outValid_q;
  logic [DW-1:0] outData_q;
  logic [31:0]   errCount_q, errCount_d;
  logic [32:0]   errSum;

  // Capture the whole configuration on cfg_apply; reset restores the pass-through setup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        mapCfg_q[i*LW +: LW] <= LW'(i);
      end
      polarCfg_q  <= '0;
      skewCfg_q   <= '0;
      modeCfg_q   <= 2'b00;
      laneCfg_q   <= '0;
      periodCfg_q <= '0;
      burstCfg_q  <= BW'(1);
    end else if (bus.cfg_apply) begin
      mapCfg_q    <= bus.cfg_map;
      polarCfg_q  <= bus.cfg_polar;
      skewCfg_q   <= bus.cfg_skew;
      modeCfg_q   <= bus.cfg_err_mode;
      laneCfg_q   <= bus.cfg_err_lane;
      periodCfg_q <= bus.cfg_err_period;
      burstCfg_q  <= bus.cfg_err_burst;
    end
  end

  // Lane selection, polarity, write pointer and per-lane tap pointer.
  always_comb begin
    wrPtr_d = wrPtr_q;
    if (bus.in_valid) begin
      wrPtr_d = (wrPtr_q == SKW'(MAX_SKEW - 1)) ? '0 : wrPtr_q + 1'b1;
    end
    for (int i = 0; i < LANES; i++) begin
      laneWord[i] = '0;
      for (int j = 0; j < LANES; j++) begin
        if (mapCfg_q[i*LW +: LW] == LW'(j)) begin
          laneWord[i] = bus.in_data[j*W +: W];
        end
      end
      if (polarCfg_q[i]) begin
        laneWord[i] = ~laneWord[i];
      end
      if (wrPtr_q >= skewCfg_q[i*SKW +: SKW]) begin
        rdPtr_d[i] = wrPtr_q - skewCfg_q[i*SKW +: SKW];
      end else begin
        rdPtr_d[i] = SKW'(MAX_SKEW + int'(wrPtr_q) - int'(skewCfg_q[i*SKW +: SKW]));
      end
    end
  end

  // Error engine: builds the flip mask of the current word and advances counters on valid words.
  always_comb begin
    periodic = (modeCfg_q == 2'b01) || (modeCfg_q == 2'b10);
    evt      = periodic && (periodCfg_q != 16'd0) && (periodCnt_q == periodCfg_q - 16'd1);
    lfsrHit  = (modeCfg_q == 2'b11) && (lfsr_q[15:0] < periodCfg_q);
    randPos  = PW'({17'd0, lfsr_q[30:16]} % 32'(W));
    flipBase = '0;
    case (modeCfg_q)
      2'b01: begin
        if (evt) flipBase[pos_q] = 1'b1;
      end
      2'b10: begin
        if (evt) begin
          for (int b = 0; b < W; b++) begin
            if ((b >= int'(pos_q)) && (b < int'(pos_q) + int'(burstCfg_q))) begin
              flipBase[b] = 1'b1;
            end
          end
        end
      end
      2'b11: begin
        if (lfsrHit) flipBase[randPos] = 1'b1;
      end
      default: ;
    endcase
    flipCnt_d = '0;
    for (int i = 0; i < LANES; i++) begin
      errMask_d[i] = laneCfg_q[i] ? flipBase : '0;
      for (int b = 0; b < W; b++) begin
        flipCnt_d = flipCnt_d + CW'(errMask_d[i][b]);
      end
    end
    periodCnt_d = periodCnt_q;
    pos_d       = pos_q;
    lfsr_d      = lfsr_q;
    if (bus.in_valid) begin
      if (periodic && (periodCfg_q != 16'd0)) begin
        periodCnt_d = (periodCnt_q >= periodCfg_q - 16'd1) ? '0 : periodCnt_q + 16'd1;
      end
      if (evt) begin
        pos_d = (pos_q == PW'(W - 1)) ? '0 : pos_q + 1'b1;
      end
      lfsr_d = {lfsr_q[29:0], lfsr_q[30] ^ lfsr_q[27]};
    end
    if (bus.cfg_apply) begin
      periodCnt_d = '0;
      pos_d       = '0;
    end
  end

  // Error engine state registers; the LFSR keeps running across configuration changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      periodCnt_q <= '0;
      pos_q       <= '0;
      lfsr_q      <= 31'h7FFF_FFFF;
    end else begin
      periodCnt_q <= periodCnt_d;
      pos_q       <= pos_d;
      lfsr_q      <= lfsr_d;
    end
  end

  // Stage 1: write the delay lines and capture tap pointer and error mask of the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q   <= '0;
      s1Valid_q <= 1'b0;
      flipCnt_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        rdPtr_q[i]   <= '0;
        errMask_q[i] <= '0;
        for (int s = 0; s < MAX_SKEW; s++) begin
          dly_q[i][s] <= '0;
        end
      end
    end else begin
      wrPtr_q   <= wrPtr_d;
      s1Valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        flipCnt_q <= flipCnt_d;
        for (int i = 0; i < LANES; i++) begin
          rdPtr_q[i]          <= rdPtr_d[i];
          errMask_q[i]        <= errMask_d[i];
          dly_q[i][wrPtr_q]   <= laneWord[i];
        end
      end
    end
  end

  // Saturating accumulation of flipped bits.
  always_comb begin
    errSum     = {1'b0, errCount_q} + 33'(flipCnt_q);
    errCount_d = errSum[32] ? 32'hFFFF_FFFF : errSum[31:0];
  end

  // Stage 2: tap read, error injection and flip counter; data holds while no word is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      errCount_q <= '0;
    end else begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        for (int i = 0; i < LANES; i++) begin
          outData_q[i*W +: W] <= dly_q[i][rdPtr_q[i]] ^ errMask_q[i];
        end
        errCount_q <= errCount_d;
      end
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.err_count = errCount_q;
endmodule

// File: tb/tb_pcs_lane_impair.sv
// Self-checking bench for pcs_lane_impair.
// A reference model keeps the full per-lane history of transformed words and the
// error-engine state. It pushes the expected output word and count for every driven
// valid word. A negedge monitor pops and compares whenever out_valid is seen.
module tb_pcs_lane_impair;
  localparam int LANES    = 4;
  localparam int W        = 40;
  localparam int MAX_SKEW = 8;
  localparam int SKW      = $clog2(MAX_SKEW);
  localparam int LW       = $clog2(LANES);
  localparam int BW       = $clog2(W) + 1;
  localparam int DW       = LANES * W;
  localparam int HMAX     = 16384;

  typedef struct {
    logic [DW-1:0] data;
    logic [31:0]   cnt;
  } ExpT;

  logic clk = 1'b0;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  // pending (driven) and active (model) configuration
  logic [LANES*LW-1:0]  pMap, aMap;
  logic [LANES-1:0]     pPolar, aPolar, pLane, aLane;
  logic [LANES*SKW-1:0] pSkew, aSkew;
  logic [1:0]           pMode, aMode;
  logic [15:0]          pPeriod, aPeriod;
  logic [BW-1:0]        pBurst, aBurst;

  // model state
  int          tN;
  int          tCnt;
  int          tPos;
  logic [30:0] tLfsr;
  longint      tErr;
  logic [W-1:0] hist [LANES][HMAX];
  ExpT         expQ[$];
  ExpT         monExp;

  always #5 clk = ~clk;

  pcs_lane_impair_if #(.LANES(LANES), .W(W), .MAX_SKEW(MAX_SKEW)) bus ();

  pcs_lane_impair #(.LANES(LANES), .W(W), .MAX_SKEW(MAX_SKEW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // one comparison: counts it and reports a mismatch
  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic driveCfg();
    bus.cfg_map        = pMap;
    bus.cfg_polar      = pPolar;
    bus.cfg_skew       = pSkew;
    bus.cfg_err_mode   = pMode;
    bus.cfg_err_lane   = pLane;
    bus.cfg_err_period = pPeriod;
    bus.cfg_err_burst  = pBurst;
  endtask

  task automatic modelReset();
    pMap = {2'd3, 2'd2, 2'd1, 2'd0};
    pPolar = '0; pSkew = '0; pMode = 2'b00; pLane = '0; pPeriod = '0; pBurst = BW'(1);
    aMap = pMap; aPolar = pPolar; aSkew = pSkew; aMode = pMode;
    aLane = pLane; aPeriod = pPeriod; aBurst = pBurst;
    tN = 0; tCnt = 0; tPos = 0; tLfsr = 31'h7FFF_FFFF; tErr = 0;
    expQ.delete();
    driveCfg();
  endtask

  // reference model of one valid word
  task automatic modelWord(input logic [DW-1:0] d);
    logic [W-1:0]  mask;
    logic [W-1:0]  w;
    logic [DW-1:0] o;
    int flips;
    int s;
    int src;
    mask = '0; o = '0; flips = 0;
    if ((aMode == 2'b01 || aMode == 2'b10) && aPeriod != 16'd0) begin
      if (tCnt == int'(aPeriod) - 1) begin
        if (aMode == 2'b01) mask[tPos] = 1'b1;
        else for (int b = tPos; b < tPos + int'(aBurst) && b < W; b++) mask[b] = 1'b1;
        tPos = (tPos + 1) % W;
        tCnt = 0;
      end else begin
        tCnt++;
      end
    end else if (aMode == 2'b11 && tLfsr[15:0] < aPeriod) begin
      mask[int'(tLfsr[30:16]) % W] = 1'b1;
    end
    tLfsr = {tLfsr[29:0], tLfsr[30] ^ tLfsr[27]};
    for (int i = 0; i < LANES; i++) begin
      src = int'(aMap[i*LW +: LW]);
      w = d[src*W +: W];
      if (aPolar[i]) w = ~w;
      hist[i][tN] = w;
      s = int'(aSkew[i*SKW +: SKW]);
      w = (tN >= s) ? hist[i][tN - s] : '0;
      if (aLane[i]) begin
        w = w ^ mask;
        flips += $countones(mask);
      end
      o[i*W +: W] = w;
    end
    tN++;
    tErr = tErr + flips;
    if (tErr > 64'd4294967295) tErr = 64'd4294967295;
    expQ.push_back('{o, 32'(tErr)});
  endtask

  // drive one cycle of stimulus; model sees the word with the old config, then the apply
  task automatic applyStimulus(input logic v, input logic ap, input logic [DW-1:0] d);
    @(posedge clk); #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.cfg_apply = ap;
    driveCfg();
    if (v) modelWord(d);
    if (ap) begin
      aMap = pMap; aPolar = pPolar; aSkew = pSkew; aMode = pMode;
      aLane = pLane; aPeriod = pPeriod; aBurst = pBurst;
      tCnt = 0; tPos = 0;
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.cfg_apply = 1'b0; bus.in_data = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drainQ(input string tag);
    int k;
    k = 0;
    while (expQ.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    checkOutput(tag, DW'(expQ.size()), '0);
  endtask

  function automatic logic [DW-1:0] ramp(input int k);
    logic [DW-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*W +: W] = {8'(i), 32'(k)};
    return d;
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] d;
    for (int c = 0; c < DW / 32; c++) d[c*32 +: 32] = $urandom;
    return d;
  endfunction

  // scoreboard monitor: compare every output word against the model
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out", DW'(1), DW'(0));
      end else begin
        monExp = expQ.pop_front();
        checkOutput("out_data", bus.out_data, monExp.data);
        checkOutput("err_count", DW'(bus.err_count), DW'(monExp.cnt));
      end
    end
  end

  initial begin
    logic [DW-1:0] x;
    logic [DW-1:0] want;
    int cnt;
    logic v;
    testsRun = 0; testsFailed = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.cfg_apply = 1'b0;
    modelReset();
    #12;
    checkOutput("rst_valid", DW'(bus.out_valid), '0);
    checkOutput("rst_data", bus.out_data, '0);
    checkOutput("rst_errcnt", DW'(bus.err_count), '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // identity with ramp data
    for (int k = 0; k < 100; k++) applyStimulus(1'b1, 1'b0, ramp(k));
    idle();
    drainQ("drain_identity");
    checkOutput("identity_errcnt", DW'(bus.err_count), '0);

    // map/polar with apply colliding with a valid word
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, rnd());
    pMap = {2'd0, 2'd1, 2'd2, 2'd3};
    pPolar = 4'b0101;
    applyStimulus(1'b1, 1'b1, rnd());
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b0, rnd());
    x = rnd();
    applyStimulus(1'b1, 1'b0, x);
    idle();
    @(posedge clk); #1;
    want = {x[0*W +: W], ~x[1*W +: W], x[2*W +: W], ~x[3*W +: W]};
    checkOutput("mappolar_spot", bus.out_data, want);
    drainQ("drain_mappolar");

    // per-lane skew with gaps
    doReset();
    pSkew = {3'd7, 3'd3, 3'd1, 3'd0};
    applyStimulus(1'b0, 1'b1, '0);
    cnt = 0;
    while (cnt < 20) begin
      v = ($urandom_range(0, 2) != 0);
      applyStimulus(v, 1'b0, ramp(cnt));
      if (v) cnt++;
    end
    idle();
    drainQ("drain_skew");

    // periodic single-bit
    doReset();
    pMode = 2'b01; pPeriod = 16'd4; pLane = 4'b0001;
    applyStimulus(1'b0, 1'b1, '0);
    for (int k = 0; k < 40; k++) applyStimulus(1'b1, 1'b0, rnd());
    idle();
    drainQ("drain_periodic");
    checkOutput("periodic_errcnt", DW'(bus.err_count), DW'(10));

    // periodic burst
    doReset();
    pMode = 2'b10; pPeriod = 16'd1; pLane = 4'b0001; pBurst = BW'(5);
    applyStimulus(1'b0, 1'b1, '0);
    for (int k = 0; k < 9; k++) applyStimulus(1'b1, 1'b0, rnd());
    idle();
    drainQ("drain_burst");
    checkOutput("burst_errcnt", DW'(bus.err_count), DW'(45));

    // pseudo-random single-bit
    doReset();
    pMode = 2'b11; pPeriod = 16'h8000; pLane = 4'hF;
    applyStimulus(1'b0, 1'b1, '0);
    for (int k = 0; k < 10000; k++) applyStimulus(1'b1, 1'b0, rnd());
    idle();
    drainQ("drain_random");
    checkOutput("random_errcnt", DW'(bus.err_count), DW'(32'(tErr)));

    // saturation from a preset near full scale
    doReset();
    pMode = 2'b10; pPeriod = 16'd1; pLane = 4'hF; pBurst = BW'(40);
    applyStimulus(1'b0, 1'b1, '0);
    idle();
    force dut.errCount_q = 32'hFFFF_FF00;
    @(negedge clk);
    release dut.errCount_q;
    tErr = 64'h0000_0000_FFFF_FF00;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, rnd());
    idle();
    drainQ("drain_sat");
    checkOutput("sat_errcnt", DW'(bus.err_count), DW'(32'hFFFF_FFFF));

    // reset asserted mid-burst
    doReset();
    pMode = 2'b10; pPeriod = 16'd1; pLane = 4'hF; pBurst = BW'(3);
    applyStimulus(1'b0, 1'b1, '0);
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, rnd());
    #3;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checkOutput("midrst_valid", DW'(bus.out_valid), '0);
    checkOutput("midrst_errcnt", DW'(bus.err_count), '0);
    checkOutput("midrst_data", bus.out_data, '0);
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, ramp(k + 1));
    idle();
    drainQ("drain_postrst");
    checkOutput("postrst_errcnt", DW'(bus.err_count), '0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/pcs_lane_impair.md
# pcs_lane_impair

Parametrised multi-lane channel impairment block placed between the PCS transmit lanes and the receive-side PCS/FEC in the 25G/28G benches. Per lane, it applies lane misconnection, polarity inversion, per-lane skew and configurable bit-error injection, all runtime-configurable. It replaces fixed single-setting stimulus with any lane count, word width and skew depth. Error injection has periodic, burst and pseudo-random modes, and a flipped-bit counter is exposed for scoreboarding.

## Interface
- LANES, 4, number of lanes
- W, 40, word width per lane (bits)
- MAX_SKEW, 8, delay-line depth in words; legal skew 0..MAX_SKEW-1
- SKW, $clog2(MAX_SKEW), skew field width
- LW, $clog2(LANES), lane index width
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word strobe, all lanes together
- in_data  in  LANES*W  lane i at [i*W +: W]
- cfg_apply  in  1  one-cycle pulse; samples all cfg_* into shadow registers
- cfg_map  in  LANES*LW  output lane i sources input lane cfg_map[i*LW +: LW]
- cfg_polar  in  LANES  1 = invert all bits of output lane i
- cfg_skew  in  LANES*SKW  delay of output lane i in valid words
- cfg_err_mode  in  2  00 off, 01 periodic single bit, 10 periodic burst, 11 random single bit
- cfg_err_lane  in  LANES  lane enable mask for injection
- cfg_err_period  in  16  period in valid words (modes 01/10); threshold (mode 11); 0 disables injection
- cfg_err_burst  in  $clog2(W)+1  burst length in bits (mode 10), 1..W
- out_valid  out  1  output word strobe
- out_data  out  LANES*W  impaired data
- err_count  out  32  total flipped bits, saturating

## Operation
- Shadow config reset: map identity, polar 0, skew 0, mode 00, lane mask 0, period 0, burst 1. Updated only on cfg_apply, effective from the cycle after the pulse. An in_valid word in the apply cycle uses the old config.
- Transform order per output lane i:
  - select input lane cfg_map[i]
  - invert if polar[i]
  - delay by skew[i] valid words
  - inject errors if err_lane[i]
- Duplicate map entries are legal; one input is copied to several outputs.
- Delay line: circular buffer per lane, MAX_SKEW words. Write pointer advances only on in_valid. Buffers reset to zero.
- Output word n of lane i equals the transformed input word n-skew[i]. For n<skew[i], the output is zero.
- A skew change takes effect on the next valid word without a flush. Words may be repeated or dropped, which is intended.
- Error engine advances only on valid words.
  - A period counter counts 0..period-1. An injection event fires when the counter equals period-1, then the counter wraps to 0.
  - A bit-position pointer pos starts at 0 and advances by 1 mod W after each event.
  - Mode 01: flip bit pos in each enabled lane.
  - Mode 10: flip bits pos..min(pos+burst-1, W-1), truncated at the word end; no wrap.
  - Mode 11: uses a 31-bit Fibonacci LFSR (x^31+x^28+1), seed all ones, stepped every valid word. If lfsr[15:0] < period, flip bit (lfsr[30:16] mod W) in each enabled lane.
  - A cfg_apply resets the period counter and pos to 0. It does not reset the LFSR.
- err_count increments by the number of bits flipped in the output word across all lanes. It saturates at 0xFFFFFFFF.

## Timing
- Reset values: out_valid 0, out_data 0, err_count 0, all pointers/counters 0, LFSR 0x7FFFFFFF.
- Latency is 2 cycles: out_valid at cycle t+2 for in_valid at t. Skew is added in valid words, not cycles.
- Stage 1 registers the mapped and polarised word and writes the delay line. Stage 2 registers the tap read and error injection.
- Gaps in in_valid propagate as gaps in out_valid. Data is held when out_valid=0.
- err_count updates in the same cycle as the corresponding out_valid.
- rst_n asserted mid-stream clears everything immediately, including shadow config. The first valid after release starts at word index 0.

## Test plan
- Identity:
  - Stimulus: reset config, ramp data lane i = {i, counter}, 100 words.
  - Required: out = in delayed 2 cycles, err_count 0.
- Map/polar:
  - Stimulus: map {3,2,1,0} with polar 4'b0101 applied.
  - Required: out lane0 = ~in lane3, out lane1 = in lane2, out lane2 = ~in lane1, out lane3 = in lane0.
- Skew:
  - Stimulus: skew {0,1,3,7}, 20 valid words with random in_valid gaps.
  - Required: lane3 emits 7 zero words, then word 0; per-lane alignment matches skew in valid words.
- Periodic/burst:
  - Stimulus: mode 01, period 4, mask 0001, 40 words.
  - Required: lane0 words 3,7,11… have bits 0,1,2… flipped; err_count=10.
  - Stimulus: mode 10, burst 5, period 1, W=40, 9 words.
  - Required: word 8 flips bits 8..12; err_count=45.
- Random and saturation:
  - Stimulus: mode 11, period 0x8000, mask 1111, 10000 words.
  - Required: err_count equals a bit-exact LFSR model count; about 20000.
  - Stimulus: force err_count preset near max.
  - Required: err_count sticks at 0xFFFFFFFF.
- Reset/apply collision:
  - Stimulus: cfg_apply together with in_valid.
  - Required: that word uses the old config, the next word uses the new config.
  - Stimulus: rst_n low mid-burst.
  - Required: out_valid=0 and err_count=0 immediately.
